// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types and command constants for the LCD bus writer.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME_MASK = 8'hFE;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_delay_counter
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_delay_counter #(
  parameter int CW = 17
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iLoad,
  input  logic [CW-1:0] iLoadValue,
  output logic          oZero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_count <= '0;
    end else if (iLoad) begin
      r_count <= iLoadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign oZero = (r_count == '0);

endmodule : lcd_delay_counter
`default_nettype wire

// File: rtl/lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_writer
// Brief    : HD44780-style write engine with setup/enable/hold timing and
//            built-in execution wait. Optional macro LCD_LONG_CMD_EN selects
//            T_LONG as the wait after clear/home commands.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 16,
  parameter int T_HOLD  = 2,
  parameter int T_CMD   = 1850,
  parameter int T_LONG  = 76000,
  parameter int CW      = 17
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iNIBBLE,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  if (T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 || T_CMD < 1) begin : g_badTiming
    $error("lcd_bus_writer: every T_* parameter must be at least 1");
  end
  if (T_SETUP >= (1 << CW) || T_EN >= (1 << CW) || T_HOLD >= (1 << CW) ||
      T_CMD >= (1 << CW) || T_LONG >= (1 << CW)) begin : g_badCw
    $error("lcd_bus_writer: CW too narrow for the largest T_* value");
  end

  localparam logic [CW-1:0] c_setupLoad = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] c_enLoad    = CW'(T_EN - 1);
  localparam logic [CW-1:0] c_holdLoad  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] c_cmdLoad   = CW'(T_CMD - 1);
`ifdef LCD_LONG_CMD_EN
  localparam logic [CW-1:0] c_longLoad  = CW'(T_LONG - 1);
`endif

  lcd_state_e    r_state;
  lcd_state_e    w_nextState;
  logic [7:0]    r_byte;
  logic          r_rs;
  logic          r_nibbleMode;
  logic          r_nibbleFlag;
  logic          w_nextFlag;
  logic          w_accept;
  logic          w_load;
  logic [CW-1:0] w_loadValue;
  logic [CW-1:0] w_waitLoad;
  logic          w_zero;
  logic [7:0]    w_byteNext;
  logic          w_rsNext;
  logic          w_nibNext;
  logic          w_busActive;
  logic [7:0]    w_busNext;

  lcd_delay_counter #(
    .CW(CW)
  ) u_delay (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iLoad     (w_load),
    .iLoadValue(w_loadValue),
    .oZero     (w_zero)
  );

  // Clear/home decode uses the whole latched byte, so 4-bit mode needs no
  // nibble reassembly.
`ifdef LCD_LONG_CMD_EN
  assign w_waitLoad = (!r_rs && (r_byte == LCD_CMD_CLEAR ||
                       (r_byte & LCD_CMD_HOME_MASK) == LCD_CMD_HOME))
                      ? c_longLoad : c_cmdLoad;
`else
  assign w_waitLoad = c_cmdLoad;
`endif

  always_comb begin
    w_nextState = r_state;
    w_nextFlag  = r_nibbleFlag;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_loadValue = '0;
    case (r_state)
      IDLE: begin
        if (iVALID) begin
          w_accept    = 1'b1;
          w_nextFlag  = 1'b0;
          w_nextState = SETUP;
          w_load      = 1'b1;
          w_loadValue = c_setupLoad;
        end
      end
      SETUP: begin
        if (w_zero) begin
          w_nextState = EN_HI;
          w_load      = 1'b1;
          w_loadValue = c_enLoad;
        end
      end
      EN_HI: begin
        if (w_zero) begin
          w_nextState = HOLD;
          w_load      = 1'b1;
          w_loadValue = c_holdLoad;
        end
      end
      HOLD: begin
        if (w_zero) begin
          w_load = 1'b1;
          if (r_nibbleMode && !r_nibbleFlag) begin
            w_nextFlag  = 1'b1;
            w_nextState = SETUP;
            w_loadValue = c_setupLoad;
          end else begin
            w_nextState = WAIT;
            w_loadValue = w_waitLoad;
          end
        end
      end
      WAIT: begin
        if (w_zero) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-cycle values so they line up with state.
  assign w_byteNext  = w_accept ? iDATA   : r_byte;
  assign w_rsNext    = w_accept ? iRS     : r_rs;
  assign w_nibNext   = w_accept ? iNIBBLE : r_nibbleMode;
  assign w_busActive = (w_nextState == SETUP) || (w_nextState == EN_HI) ||
                       (w_nextState == HOLD);

  always_comb begin
    w_busNext = 8'h00;
    if (w_busActive) begin
      if (w_nibNext) begin
        w_busNext = {(w_nextFlag ? w_byteNext[3:0] : w_byteNext[7:4]), 4'b0000};
      end else begin
        w_busNext = w_byteNext;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= IDLE;
      r_byte       <= 8'h00;
      r_rs         <= 1'b0;
      r_nibbleMode <= 1'b0;
      r_nibbleFlag <= 1'b0;
      oREADY       <= 1'b1;
      oDone        <= 1'b0;
      LCD_DATA     <= 8'h00;
      LCD_EN       <= 1'b0;
      LCD_RS       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_byte       <= w_byteNext;
      r_rs         <= w_rsNext;
      r_nibbleMode <= w_nibNext;
      r_nibbleFlag <= w_nextFlag;
      oREADY       <= (w_nextState == IDLE);
      oDone        <= (w_nextState == DONE);
      LCD_DATA     <= w_busNext;
      LCD_EN       <= (w_nextState == EN_HI);
      LCD_RS       <= w_busActive ? w_rsNext : 1'b0;
    end
  end

  assign LCD_RW = 1'b0;

endmodule : lcd_bus_writer
`default_nettype wire

// File: tb/tb_lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_writer
// Brief    : Scoreboard bench for lcd_bus_writer with a cycle-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_writer;

  localparam int TS = 2;
  localparam int TE = 4;
  localparam int TH = 2;
  localparam int TC = 10;
  localparam int TL = 50;
  localparam int P  = TS + TE + TH;

  typedef struct {
    logic [7:0] d;
    logic       rs;
    logic       nib;
  } req_t;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iNIBBLE;
  logic       iVALID;
  logic       oREADY;
  logic       oDone;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  int   nCompared = 0;
  int   nMismatch = 0;
  req_t expQ[$];
  bit   active  = 1'b0;
  bit   pending = 1'b0;
  req_t cur;
  int   k;
  int   curBusy;

  lcd_bus_writer #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_LONG(TL), .CW(17)
  ) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iDATA   (iDATA),
    .iRS     (iRS),
    .iNIBBLE (iNIBBLE),
    .iVALID  (iVALID),
    .oREADY  (oREADY),
    .oDone   (oDone),
    .LCD_DATA(LCD_DATA),
    .LCD_RW  (LCD_RW),
    .LCD_EN  (LCD_EN),
    .LCD_RS  (LCD_RS)
  );

  always #5 iCLK = ~iCLK;

  function automatic int waitOf(req_t r);
`ifdef LCD_LONG_CMD_EN
    if (!r.rs && (r.d == 8'h01 || r.d == 8'h02 || r.d == 8'h03)) return TL;
`endif
    return TC;
  endfunction

  function automatic int busyOf(req_t r);
    return (r.nib ? 2 : 1) * P + waitOf(r) + 1;
  endfunction

  function automatic logic [12:0] observed();
    return {LCD_RW, oREADY, oDone, LCD_EN, LCD_RS, LCD_DATA};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got {rw,rdy,done,en,rs,data}=%b_%h required %b_%h",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  // Monitor: expected waveform of each transfer derived from the phase lengths.
  always @(negedge iCLK) begin
    logic [12:0] e;
    logic [12:0] m;
    int act;
    int j;
    if (!iRST_N) begin
      active  = 1'b0;
      pending = 1'b0;
      expQ.delete();
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (expQ.size() == 0) begin
          check("unexpected_accept", 13'h0001, 13'h0000);
        end else begin
          cur     = expQ.pop_front();
          curBusy = busyOf(cur);
          k       = 0;
          active  = 1'b1;
        end
      end
      if (active) begin
        act = (cur.nib ? 2 : 1) * P;
        e   = '0;
        if (k < act) begin
          j = k % P;
          m = 13'h1FFF;
          e[9] = (j >= TS) && (j < TS + TE);
          e[8] = cur.rs;
          if (!cur.nib)          e[7:0] = cur.d;
          else if (k / P == 0)   e[7:0] = {cur.d[7:4], 4'h0};
          else                   e[7:0] = {cur.d[3:0], 4'h0};
          check("bus_phase", observed() & m, e);
        end else begin
          m = 13'h1E00;
          e[10] = (k == curBusy - 1);
          check(e[10] ? "done_cycle" : "exec_wait", observed() & m, e);
        end
        k++;
        if (k == curBusy) active = 1'b0;
      end else begin
        check("idle", observed() & 13'h1E00, 13'h0800);
        if (iVALID && oREADY) pending = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic rs, input logic nib, input bit keep);
    req_t r;
    int   t;
    @(posedge iCLK); #1;
    iDATA = d; iRS = rs; iNIBBLE = nib; iVALID = 1'b1;
    t = 0;
    forever begin
      @(negedge iCLK);
      if (oREADY) break;
      t++;
      if (t > 500) begin
        check("ready_timeout", 13'h0000, 13'h0800);
        iVALID = 1'b0;
        return;
      end
    end
    r.d = d; r.rs = rs; r.nib = nib;
    expQ.push_back(r);
    @(posedge iCLK); #1;
    if (!keep) iVALID = 1'b0;
    iDATA = 8'($urandom); iRS = 1'($urandom); iNIBBLE = 1'($urandom);
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (expQ.size() != 0 || active || pending) begin
      @(negedge iCLK);
      t++;
      if (t > 2000) begin
        check("drain_timeout", 13'h0001, 13'h0000);
        return;
      end
    end
    @(negedge iCLK);
  endtask

  initial begin
    int t;
    iRST_N = 1'b0; iVALID = 1'b0; iDATA = 8'h00; iRS = 1'b0; iNIBBLE = 1'b0;
    repeat (3) @(posedge iCLK);
    #1 check("reset_state", observed(), 13'h0800);
    iRST_N = 1'b1;

    send(8'h41, 1'b1, 1'b0, 1'b0);
    waitIdle();
    send(8'h28, 1'b0, 1'b1, 1'b0);
    waitIdle();

    // Busy rejection: 8'h55 raised during EN high must wait for IDLE.
    send(8'h41, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge iCLK);
    send(8'h55, 1'b0, 1'b0, 1'b0);
    waitIdle();

    // Clear/home versus data of the same value, both widths.
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b1, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b1, 1'b0);
    send(8'h04, 1'b0, 1'b0, 1'b0);
    waitIdle();

    // Back-to-back with iVALID held high.
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    send(8'h7E, 1'b0, 1'b0, 1'b0);
    waitIdle();

    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge iCLK);
    end
    iVALID = 1'b0;
    waitIdle();

    // Reset while EN is high.
    send(8'hC3, 1'b1, 1'b1, 1'b0);
    t = 0;
    while (!LCD_EN && t < 100) begin
      @(negedge iCLK);
      t++;
    end
    if (t >= 100) check("en_timeout", 13'h0000, 13'h0200);
    #3 iRST_N = 1'b0;
    #1 check("async_reset", observed(), 13'h0800);
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    repeat (30) @(negedge iCLK);

    send(8'h5A, 1'b1, 1'b0, 1'b0);
    send(8'hE1, 1'b0, 1'b1, 1'b0);
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule : tb_lcd_bus_writer
`default_nettype wire

// File: doc/lcd_bus_writer.md
Name: lcd_bus_writer

Overview:
- Parametrised HD44780-style LCD write engine.
- Accepts one character or command per valid/ready handshake and drives the LCD bus with programmable setup, enable-pulse and hold timing.
- Supports 8-bit or 4-bit (two-nibble) transfers and inserts the post-write execution delay itself, so the host sequencer needs no wait counters.
- Sits between the text/init sequencer and the LCD pins.

Parameters:
- T_SETUP, 2: cycles RS/DATA are stable with EN low before EN rises (>=1).
- T_EN, 16: cycles EN is held high (>=1).
- T_HOLD, 2: cycles RS/DATA are held after EN falls (>=1).
- T_CMD, 1850: post-write execution wait in cycles (37 us at 50 MHz) (>=1).
- T_LONG, 76000: wait after clear/home commands (1.52 ms at 50 MHz), optional feature only.
- CW, 17: delay counter width; must hold the largest T_* value (elaboration assertion).

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iDATA  in  8  command/character byte, sampled at accept
- iRS  in  1  register select (0 = command, 1 = data), sampled at accept
- iNIBBLE  in  1  1 = 4-bit transfer (high nibble then low nibble), sampled at accept
- iVALID  in  1  request valid
- oREADY  out  1  engine idle, can accept
- oDone  out  1  one-cycle pulse when a transfer, including its execution wait, completes
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  tied 0 (write only)
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select

Behaviour:
- Clock and reset: one clock, iCLK. Reset is iRST_N, asynchronous and active-low.
- Reset values: oREADY=1, oDone=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0, LCD_RW=0, state IDLE, counter 0, nibble flag 0.
- Reset mid-operation: all outputs return to reset values immediately and the transfer is discarded.
- Outputs: all are registered. LCD_RW is constant 0.
- Accept: on a rising edge with iVALID=1 and oREADY=1, latch iDATA, iRS and iNIBBLE, and go to SETUP. oREADY=1 only in IDLE.
  - iVALID while busy is ignored; there is no queue.
  - Input changes after accept have no effect.
- Bus drive in 8-bit mode: LCD_DATA = the latched byte.
- Bus drive in 4-bit mode: LCD_DATA[7:4] = current nibble (high first) and LCD_DATA[3:0] = 0.
- LCD_RS equals the latched RS from SETUP through HOLD.
- FSM:
  - IDLE -> SETUP on accept.
  - SETUP: T_SETUP cycles, EN=0 -> EN_HI.
  - EN_HI: T_EN cycles, EN=1 -> HOLD.
  - HOLD: T_HOLD cycles, EN=0, bus stable. Then, if 4-bit mode and the high nibble was just sent, set the nibble flag and go to SETUP (low nibble); otherwise go to WAIT.
  - WAIT: T_CMD cycles, EN=0 -> DONE.
  - DONE: 1 cycle, oDone=1, oREADY=0 -> IDLE.
- Busy duration, from the accept edge to oREADY high again:
  - 8-bit: T_SETUP+T_EN+T_HOLD+T_CMD+1 cycles.
  - 4-bit: 2*(T_SETUP+T_EN+T_HOLD)+T_CMD+1 cycles.
- Counter: loads (T_x - 1) on state entry, decrements, and transitions at 0. It never wraps.
- Back-to-back: iVALID held high gives accept on the first cycle of IDLE after DONE, so there is a 1-cycle gap between oDone and the next SETUP.

Optional Feature:
- Macro: LCD_LONG_CMD_EN.
- Defined: a command with RS=0 and byte 8'h01 (clear) or 8'b0000_001x (home) uses T_LONG in WAIT instead of T_CMD. In 4-bit mode the full reassembled byte is checked.
- Undefined: every transfer uses T_CMD, and T_LONG is unused. The host must then pad clear/home itself.

Decomposition:
- Package lcd_pkg holds:
  - state enum: IDLE, SETUP, EN_HI, HOLD, WAIT, DONE;
  - constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME_MASK=8'hFE / LCD_CMD_HOME=8'h02.
- One sub-module, lcd_delay_counter: CW-bit down-counter with load value, load strobe and zero flag. It is shared by all timed states.

Test Plan:
- Test parameters: T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10.
- 8-bit write: iDATA=8'h41, iRS=1, iNIBBLE=0 -> LCD_DATA=8'h41, RS=1, EN high for exactly 4 cycles after 2 setup cycles; oDone pulse at cycle 19 after accept; oREADY low for 19 cycles.
- 4-bit write: iDATA=8'h28, iRS=0, iNIBBLE=1 -> two EN pulses, LCD_DATA=8'h20 then 8'h80; oDone after 2*8+10+1=27 cycles.
- Busy rejection: second iVALID with 8'h55 raised during EN_HI -> ignored; only 8'h41 appears on the bus; the next accept happens only in IDLE.
- Reset mid-pulse: deassert iRST_N while EN=1 -> EN, RS and DATA go to 0 asynchronously; oREADY=1 after release; no oDone.
- Long command with LCD_LONG_CMD_EN and T_LONG=50: iDATA=8'h01, iRS=0 -> WAIT lasts 50 cycles. iDATA=8'h01 with iRS=1 -> WAIT lasts 10 cycles. Without the macro, both last 10 cycles.
- Back-to-back: iVALID held high with 3 bytes -> exactly 3 oDone pulses, 1 idle cycle between transfers, byte order preserved.
